// File: rtl/deskew_ctrl_v2.sv
// Lane deskew controller: measures per-lane alignment-marker arrival offsets, loads FIFO
// delays, then monitors marker rounds and drops lock. Optional macro: DESKEW_SKEW_CHECK_EN.
module deskew_ctrl_v2 #(
  parameter int N_LANES      = 20,
  parameter int MAX_SKEW     = 16,
  parameter int NB_COUNT     = $clog2(MAX_SKEW + 1),
  parameter int N_BAD_ROUNDS = 3,
  parameter int NB_BAD       = $clog2(N_BAD_ROUNDS + 1)
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_enable,
  input  logic                        i_resync,
  input  logic [N_LANES-1:0]          i_start_of_lane,
  output logic [N_LANES*NB_COUNT-1:0] o_fifo_delay,
  output logic                        o_set_fifo_delay,
  output logic                        o_deskew_done,
  output logic                        o_invalid_skew,
  output logic                        o_deskew_lost,
  output logic [N_LANES-1:0]          o_lane_seen
);

  typedef enum logic [1:0] {ST_INIT, ST_COUNT, ST_LOCKED, ST_MONITOR} state_t;

  localparam logic [NB_COUNT-1:0] CNT_SAT   = NB_COUNT'(MAX_SKEW + 1);
  localparam logic [NB_COUNT-1:0] SKEW_LIM  = NB_COUNT'(MAX_SKEW);
  localparam logic [NB_BAD-1:0]   BAD_LIM   = NB_BAD'(N_BAD_ROUNDS);
  localparam logic [N_LANES-1:0]  ALL_LANES = {N_LANES{1'b1}};

  state_t                      state_q, state_d;
  logic [NB_COUNT-1:0]         cnt_q, cnt_d;
  logic [N_LANES-1:0]          seen_q, seen_d;
  logic [NB_COUNT-1:0]         off_q [N_LANES];
  logic [NB_COUNT-1:0]         off_d [N_LANES];
  logic [NB_BAD-1:0]           bad_q, bad_d;
  logic [N_LANES*NB_COUNT-1:0] delay_q, delay_d;
  logic                        set_q, set_d, inv_q, inv_d, lost_q, lost_d;
`ifdef DESKEW_SKEW_CHECK_EN
  logic                        drift_q, drift_d;
`endif

  logic [N_LANES-1:0]  new_lanes, mon_seen;
  logic [NB_COUNT-1:0] mon_cnt;
  logic                all_seen, mon_all, drift_now, round_good, round_bad;

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] v);
    return (v >= CNT_SAT) ? CNT_SAT : v + NB_COUNT'(1);
  endfunction

  function automatic logic [NB_COUNT-1:0] lane_delay(input logic [NB_COUNT-1:0] max_off,
                                                     input logic [NB_COUNT-1:0] off);
    return max_off - off;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    off_d   = off_q;
    bad_d   = bad_q;
    delay_d = delay_q;
    set_d   = 1'b0;
    inv_d   = 1'b0;
    lost_d  = 1'b0;

    new_lanes = i_start_of_lane & ~seen_q;
    all_seen  = ((seen_q | i_start_of_lane) == ALL_LANES);
    // A round opened from LOCKED is evaluated as if already in MONITOR at count 0
    mon_seen  = (state_q == ST_MONITOR) ? seen_q : '0;
    mon_cnt   = (state_q == ST_MONITOR) ? cnt_q : '0;
    mon_all   = ((mon_seen | i_start_of_lane) == ALL_LANES);
`ifdef DESKEW_SKEW_CHECK_EN
    drift_d   = drift_q;
    drift_now = (state_q == ST_MONITOR) && drift_q;
    for (int k = 0; k < N_LANES; k++) begin
      if (i_start_of_lane[k] && !mon_seen[k] && (mon_cnt != off_q[k])) drift_now = 1'b1;
    end
`else
    drift_now = 1'b0;
`endif
    round_good = mon_all && (mon_cnt <= SKEW_LIM) && !drift_now;
    round_bad  = !round_good && (mon_all || (mon_cnt > SKEW_LIM));

    if (i_enable) begin
      unique case (state_q)
        ST_INIT: begin
          if (|i_start_of_lane) begin
            for (int k = 0; k < N_LANES; k++) off_d[k] = '0;
            if (i_start_of_lane == ALL_LANES) begin
              state_d = ST_LOCKED;
              delay_d = '0;
              set_d   = 1'b1;
            end else begin
              state_d = ST_COUNT;
              seen_d  = i_start_of_lane;
              cnt_d   = NB_COUNT'(1);
            end
          end
        end
        ST_COUNT: begin
          for (int k = 0; k < N_LANES; k++) begin
            if (new_lanes[k]) off_d[k] = cnt_q;
          end
          seen_d = seen_q | i_start_of_lane;
          cnt_d  = sat_inc(cnt_q);
          if (all_seen) begin
            for (int k = 0; k < N_LANES; k++) begin
              delay_d[k*NB_COUNT +: NB_COUNT] = lane_delay(cnt_q, off_d[k]);
            end
            set_d   = 1'b1;
            state_d = ST_LOCKED;
            seen_d  = '0;
            cnt_d   = '0;
          end else if (cnt_q > SKEW_LIM) begin
            inv_d   = 1'b1;
            state_d = ST_INIT;
            seen_d  = '0;
            cnt_d   = '0;
          end
        end
        ST_LOCKED, ST_MONITOR: begin
          if ((state_q == ST_MONITOR) || (|i_start_of_lane)) begin
            state_d = ST_MONITOR;
            seen_d  = mon_seen | i_start_of_lane;
            cnt_d   = sat_inc(mon_cnt);
`ifdef DESKEW_SKEW_CHECK_EN
            drift_d = drift_now;
`endif
            if (round_good || round_bad) begin
              state_d = ST_LOCKED;
              seen_d  = '0;
              cnt_d   = '0;
`ifdef DESKEW_SKEW_CHECK_EN
              drift_d = 1'b0;
`endif
              if (round_good) begin
                bad_d = '0;
              end else if ((bad_q + NB_BAD'(1)) == BAD_LIM) begin
                bad_d   = '0;
                lost_d  = 1'b1;
                state_d = ST_INIT;
              end else begin
                bad_d = bad_q + NB_BAD'(1);
              end
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Control state: cleared by reset and by resync alike
  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_resync) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      seen_q  <= '0;
      bad_q   <= '0;
      set_q   <= 1'b0;
      inv_q   <= 1'b0;
      lost_q  <= 1'b0;
      for (int k = 0; k < N_LANES; k++) off_q[k] <= '0;
`ifdef DESKEW_SKEW_CHECK_EN
      drift_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      bad_q   <= bad_d;
      set_q   <= set_d;
      inv_q   <= inv_d;
      lost_q  <= lost_d;
      off_q   <= off_d;
`ifdef DESKEW_SKEW_CHECK_EN
      drift_q <= drift_d;
`endif
    end
  end

  // FIFO delays survive a resync so the FIFOs keep their last alignment
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      delay_q <= '0;
    end else if (!i_resync) begin
      delay_q <= delay_d;
    end
  end

  assign o_fifo_delay     = delay_q;
  assign o_set_fifo_delay = set_q;
  assign o_deskew_done    = (state_q == ST_LOCKED) || (state_q == ST_MONITOR);
  assign o_invalid_skew   = inv_q;
  assign o_deskew_lost    = lost_q;
  assign o_lane_seen      = seen_q;

endmodule

// File: doc/deskew_ctrl_v2.md
Name: deskew_ctrl_v2

Overview:
Parametrised lane deskew controller for the PCS receive path. It sits between the per-lane alignment-marker lock blocks and the per-lane deskew FIFOs. It measures each lane's arrival offset internally and emits the FIFO delay for every lane. After lock it keeps checking alignment-marker rounds and drops lock after a programmable number of consecutive bad rounds.

Parameters:
N_LANES, 20, number of PCS lanes
MAX_SKEW, 16, maximum tolerated skew in enabled cycles between first and last lane
NB_COUNT, $clog2(MAX_SKEW+1), width of offset/delay/counter fields
N_BAD_ROUNDS, 3, consecutive failed monitor rounds before lock is dropped
NB_BAD, $clog2(N_BAD_ROUNDS+1), bad-round counter width

Ports:
i_clock  in  1  system clock
i_reset_n  in  1  synchronous reset, active low
i_enable  in  1  clock enable; no register updates when low
i_resync  in  1  synchronous restart to INIT
i_start_of_lane  in  N_LANES  per-lane alignment-marker-seen strobe
o_fifo_delay  out  N_LANES*NB_COUNT  packed per-lane FIFO delay; lane k at bits [k*NB_COUNT +: NB_COUNT]
o_set_fifo_delay  out  1  one-cycle pulse; FIFOs load o_fifo_delay
o_deskew_done  out  1  level; lanes aligned and locked
o_invalid_skew  out  1  one-cycle pulse; acquisition exceeded MAX_SKEW
o_deskew_lost  out  1  one-cycle pulse; lock dropped by monitor
o_lane_seen  out  N_LANES  lanes seen in the current acquisition or monitor round

Behaviour:
- Reset (i_reset_n=0 at clock edge):
  - state=INIT; counter, offsets, bad count and o_lane_seen cleared.
  - All outputs 0; o_fifo_delay=0.
- Priority: reset > i_resync > i_enable. i_resync acts as reset except o_fifo_delay holds its last value.
- All transitions and counter updates occur only on enabled cycles. Pulses last exactly one clock.
- States: INIT, COUNT, LOCKED, MONITOR.
- INIT:
  - On any i_start_of_lane bit: latch seen mask; offset=0 for those lanes; cnt<=1; go to COUNT.
  - If all lanes assert together: go directly to LOCKED with all delays 0.
- COUNT, each enabled cycle:
  - Lanes asserting while their seen bit is still clear latch offset=cnt and set their seen bit.
  - Repeat strobes from already-seen lanes are ignored.
  - cnt increments, saturating at MAX_SKEW+1.
- COUNT completion: when seen|i_start_of_lane is all ones (same cycle counts):
  - max_off=cnt.
  - Next cycle: o_fifo_delay[k]=max_off-offset[k] registered, o_set_fifo_delay=1, state=LOCKED.
- COUNT failure: if cnt>MAX_SKEW with lanes missing:
  - o_invalid_skew=1; clear seen; go to INIT.
  - Completion and failure in the same cycle: completion wins.
- LOCKED: o_deskew_done=1.
  - First i_start_of_lane bit starts a monitor round: go to MONITOR with cnt=1 and the seen mask latched.
- MONITOR: o_deskew_done stays 1; counting is identical to COUNT, but offsets are not reloaded.
  - Good round: all lanes seen with cnt<=MAX_SKEW. Clear bad count; go to LOCKED.
  - Bad round: timeout. bad<=bad+1; go to LOCKED.
  - If the bad count reaches N_BAD_ROUNDS: o_deskew_lost=1, o_deskew_done=0, go to INIT.
- o_deskew_done deasserts in the same cycle the state leaves LOCKED/MONITOR for INIT.
- Arithmetic: offsets unsigned NB_COUNT; delay subtraction never underflows, since max_off is at least every offset.

Optional Feature:
Macro DESKEW_SKEW_CHECK_EN.
- Defined: in MONITOR, a lane whose arrival cnt differs from its stored offset (relative to round start) also marks the round bad. The check detects skew drift while still within MAX_SKEW.
- Not defined: only the MAX_SKEW timeout marks a round bad; no per-lane offset storage beyond what acquisition needs.

Test Plan:
- All 20 lanes strobed in one cycle from INIT:
  - o_set_fifo_delay pulses 1 cycle later; all delays 0.
  - o_deskew_done=1.
- Lane 0 at t0, lanes 1–19 at t0+5:
  - lane0 delay=5, others 0.
  - Lock 1 cycle after last strobe.
- Lane 3 never strobes:
  - o_invalid_skew pulses when cnt reaches MAX_SKEW+1=17 cycles after first strobe.
  - Returns to INIT.
- Locked, then 3 consecutive rounds with lane 7 missing:
  - o_deskew_lost pulses on the third timeout; done drops.
  - Two bad rounds followed by a good one clear the count.
- i_enable toggled 50% during acquisition: offsets counted in enabled cycles only.
- i_resync mid-COUNT and i_reset_n=0 mid-MONITOR:
  - Next cycle state INIT, outputs 0.
  - o_fifo_delay retained on resync only.
